// File: rtl/led_pkg.sv
// Shared types and defaults for the LED frame controller: FSM state encoding,
// default geometry and a counter-width helper.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    localparam int DEF_CHANNELS   = 24;
    localparam int DEF_BITS       = 16;
    localparam int DEF_CLKDIV     = 4;
    localparam int DEF_LAT_CYCLES = 8;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_frame_ctrl_if.sv
// Bundle of the frame-request, framebuffer-read and LED-driver signals of
// led_frame_ctrl, with the controller (master) and host/driver (slave) views.
interface led_frame_ctrl_if #(
    parameter int P_BITS   = 16,
    parameter int P_ADDR_W = 5
);
    // Handshake: start is a level request taken only while the controller is
    // idle (busy=0); rd is a one-cycle strobe with addr valid, and data must be
    // presented on the cycle immediately after rd (no ready/backpressure).
    logic                start;
    logic                busy;
    logic                done;
    logic                rd;
    logic [P_ADDR_W-1:0] addr;
    logic [P_BITS-1:0]   data;
    logic                sclk;
    logic                dai;
    logic                lat;

    modport master (
        input  start, data,
        output busy, done, rd, addr, sclk, dai, lat
    );

    modport slave (
        output start, data,
        input  busy, done, rd, addr, sclk, dai, lat
    );

endinterface

// File: rtl/led_bit_timer.sv
// Serial-clock timing for one channel: P_CLKDIV cycles low then P_CLKDIV high
// per bit, P_BITS bits. Held cleared whenever en is low.
module led_bit_timer
    import led_pkg::*;
#(
    parameter int P_BITS   = DEF_BITS,
    parameter int P_CLKDIV = DEF_CLKDIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase_high,
    output logic bit_end,
    output logic last_bit
);

    localparam int PH_W  = cnt_width(P_CLKDIV);
    localparam int BIT_W = cnt_width(P_BITS);
    localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(P_CLKDIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(P_BITS - 1);

    logic [PH_W-1:0]  phase_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             high_q;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            high_q    <= 1'b0;
        end else if (phase_cnt == PH_MAX) begin
            phase_cnt <= '0;
            high_q    <= ~high_q;
            if (high_q) begin
                bit_cnt <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
            end
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // bit_end marks the final cycle of a bit's high phase.
    assign phase_high = high_q;
    assign bit_end    = en && high_q && (phase_cnt == PH_MAX);
    assign last_bit   = bit_end && (bit_cnt == BIT_MAX);

endmodule

// File: rtl/led_frame_ctrl.sv
// LED frame controller: reads P_CHANNELS words from a framebuffer, shifts each
// out MSB-first on o_clk/o_dai, then pulses o_lat to latch the driver.
module led_frame_ctrl
    import led_pkg::*;
#(
    parameter int P_CHANNELS   = DEF_CHANNELS,
    parameter int P_BITS       = DEF_BITS,
    parameter int P_CLKDIV     = DEF_CLKDIV,
    parameter int P_LAT_CYCLES = DEF_LAT_CYCLES
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_rd,
    output logic [$clog2(P_CHANNELS)-1:0] o_addr,
    input  logic [P_BITS-1:0]             i_data,
    output logic                          o_clk,
    output logic                          o_dai,
    output logic                          o_lat,
    output state_t                        o_state
);

    localparam int ADDR_W = $clog2(P_CHANNELS);
    localparam int LAT_W  = cnt_width(P_LAT_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(P_CHANNELS - 1);
    localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(P_LAT_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_next;
    logic [LAT_W-1:0]    lat_cnt;
    logic [LAT_W-1:0]    lat_cnt_next;
    logic [P_BITS-1:0]   shreg;
    logic                busy_q;
    logic                done_q;
    logic                rd_q;
    logic                lat_q;
    logic                phase_high;
    logic                bit_end;
    logic                last_bit;

    led_bit_timer #(
        .P_BITS   (P_BITS),
        .P_CLKDIV (P_CLKDIV)
    ) u_timer (
        .clk        (i_clk),
        .rst        (i_rst),
        .en         (state == ST_SHIFT),
        .phase_high (phase_high),
        .bit_end    (bit_end),
        .last_bit   (last_bit)
    );

    always_comb begin
        state_next   = state;
        addr_next    = addr_q;
        lat_cnt_next = '0;
        unique case (state)
            ST_IDLE:  if (i_start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (last_bit) begin
                    if (addr_q < ADDR_MAX) begin
                        addr_next  = addr_q + 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (lat_cnt == LAT_MAX) state_next = ST_IDLE;
                else                    lat_cnt_next = lat_cnt + 1'b1;
            end
            default:  state_next = ST_IDLE;
        endcase
        if (state_next == ST_IDLE) addr_next = '0;
    end

    // Strobes are registered from the next state so they align with the state
    // they describe; zeros are shifted in so o_dai idles low after each word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            lat_cnt <= '0;
            shreg   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            lat_q   <= 1'b0;
        end else begin
            state   <= state_next;
            addr_q  <= addr_next;
            lat_cnt <= lat_cnt_next;
            busy_q  <= (state_next != ST_IDLE);
            done_q  <= (state == ST_LATCH) && (state_next == ST_IDLE);
            rd_q    <= (state_next == ST_FETCH);
            lat_q   <= (state_next == ST_LATCH);
            if (state == ST_LOAD)  shreg <= i_data;
            else if (bit_end)      shreg <= shreg << 1;
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_rd    = rd_q;
    assign o_addr  = addr_q;
    assign o_clk   = phase_high;
    assign o_dai   = shreg[P_BITS-1];
    assign o_lat   = lat_q;
    assign o_state = state;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Randomized scoreboard bench for led_frame_ctrl with a small geometry
// (2 channels x 4 bits, clkdiv 2, latch 3 cycles).
module tb_led_frame_ctrl;
    import led_pkg::*;

    localparam int C  = 2;
    localparam int B  = 4;
    localparam int D  = 2;
    localparam int L  = 3;
    localparam int AW = $clog2(C);
    localparam int FRAME_LEN = C * (2 + 2 * B * D) + L;
    localparam logic [3:0] K_RD   = 4'd1;
    localparam logic [3:0] K_DAI  = 4'd2;
    localparam logic [3:0] K_LAT  = 4'd3;
    localparam logic [3:0] K_DONE = 4'd4;

    // ---------------- clock / reset ----------------
    logic   i_clk = 1'b0;
    logic   i_rst = 1'b1;
    state_t dbg_state;

    always #5 i_clk = ~i_clk;

    led_frame_ctrl_if #(.P_BITS(B), .P_ADDR_W(AW)) bus ();

    led_frame_ctrl #(
        .P_CHANNELS   (C),
        .P_BITS       (B),
        .P_CLKDIV     (D),
        .P_LAT_CYCLES (L)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (bus.start),
        .o_busy  (bus.busy),
        .o_done  (bus.done),
        .o_rd    (bus.rd),
        .o_addr  (bus.addr),
        .i_data  (bus.data),
        .o_clk   (bus.sclk),
        .o_dai   (bus.dai),
        .o_lat   (bus.lat),
        .o_state (dbg_state)
    );

    // Framebuffer: data appears the cycle after rd, garbage otherwise.
    logic [B-1:0] ram [C];
    always @(posedge i_clk) begin
        if (bus.rd) bus.data <= ram[bus.addr];
        else        bus.data <= B'($urandom);
    end

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int checks   = 0;
    int passes   = 0;
    int done_cnt = 0;
    int done_cyc[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic string kind_name(input logic [3:0] k);
        case (k)
            K_RD:    return "rd_addr";
            K_DAI:   return "dai_bit";
            K_LAT:   return "lat_width";
            K_DONE:  return "busy_len";
            default: return "event";
        endcase
    endfunction

    task automatic expect_event(input logic [3:0] kind, input logic [11:0] val);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_%s: got value %0d, expected no event (cycle %0d)",
                     kind_name(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            check(kind_name(kind), {kind, val}, e);
        end
    endtask

    // Reference model: a frame is, per channel, one read of that address and
    // its bits MSB-first, then the latch pulse and the o_done with busy length.
    task automatic push_frame();
        for (int ch = 0; ch < C; ch++) begin
            exp_q.push_back({K_RD, 12'(ch)});
            for (int b = B - 1; b >= 0; b--) exp_q.push_back({K_DAI, 11'd0, ram[ch][b]});
        end
        exp_q.push_back({K_LAT, 12'(L)});
        exp_q.push_back({K_DONE, 12'(FRAME_LEN)});
    endtask

    // ---------------- monitor ----------------
    logic prev_sclk = 1'b0;
    logic prev_dai  = 1'b0;
    int   busy_cnt  = 0;
    int   lat_cnt   = 0;

    always @(negedge i_clk) begin
        if (bus.sclk && !prev_sclk) expect_event(K_DAI, {11'd0, bus.dai});
        if (bus.sclk) check("dai_stable_high", 16'(bus.dai), 16'(prev_dai));
        if (bus.rd) expect_event(K_RD, 12'(bus.addr));
        if (bus.lat) begin
            lat_cnt++;
            check("lat_clk_dai_low", {14'd0, bus.sclk, bus.dai}, 16'd0);
        end else if (lat_cnt != 0) begin
            expect_event(K_LAT, 12'(lat_cnt));
            lat_cnt = 0;
        end
        if (bus.done) begin
            check("done_busy_low", 16'(bus.busy), 16'd0);
            expect_event(K_DONE, 12'(busy_cnt));
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (bus.busy) busy_cnt++;
        else          busy_cnt = 0;
        prev_sclk = bus.sclk;
        prev_dai  = bus.dai;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic pulse_start();
        @(negedge i_clk) bus.start = 1'b1;
        @(negedge i_clk) bus.start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            $display("FAIL done_timeout: got %0d dones, expected %0d within %0d cycles",
                     done_cnt, target, budget);
        end
        @(negedge i_clk);
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < C; i++) ram[i] = B'($urandom_range(0, (1 << B) - 1));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 16'(bus.busy), 16'd0);
        check({tag, "_done"}, 16'(bus.done), 16'd0);
        check({tag, "_rd"},   16'(bus.rd),   16'd0);
        check({tag, "_addr"}, 16'(bus.addr), 16'd0);
        check({tag, "_clk"},  16'(bus.sclk), 16'd0);
        check({tag, "_dai"},  16'(bus.dai),  16'd0);
        check({tag, "_lat"},  16'(bus.lat),  16'd0);
        check({tag, "_state"}, 16'(dbg_state), 16'(ST_IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int n;
        int rises;
        logic prev;
        bus.start = 1'b0;
        for (int i = 0; i < C; i++) ram[i] = '0;

        repeat (3) @(posedge i_clk);
        #1;
        check_zero_outputs("reset");
        @(negedge i_clk) i_rst = 1'b0;
        idle(2);

        // Fixed pattern A,5 -> bits 1010 0101.
        ram[0] = 4'hA;
        ram[1] = 4'h5;
        push_frame();
        d0 = done_cnt;
        pulse_start();
        wait_dones(d0 + 1, FRAME_LEN + 20);

        for (int f = 0; f < 4; f++) begin
            randomize_ram();
            push_frame();
            d0 = done_cnt;
            pulse_start();
            wait_dones(d0 + 1, FRAME_LEN + 20);
            idle($urandom_range(0, 3));
        end

        // Start held high: exactly two frames, second launched in the done cycle.
        randomize_ram();
        push_frame();
        push_frame();
        d0 = done_cnt;
        @(negedge i_clk) bus.start = 1'b1;
        repeat (60) @(negedge i_clk);
        bus.start = 1'b0;
        wait_dones(d0 + 2, 2 * FRAME_LEN + 20);
        idle(60);
        check("held_start_frames", 16'(done_cnt - d0), 16'd2);
        if (done_cyc.size() >= 2)
            check("done_spacing", 16'(done_cyc[$] - done_cyc[$-1]), 16'(FRAME_LEN + 1));
        else begin
            checks++;
            $display("FAIL done_spacing: got %0d done pulses, expected at least 2", done_cyc.size());
        end

        // Start pulsed during SHIFT is ignored.
        randomize_ram();
        push_frame();
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!bus.sclk && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("start_in_shift_state", 16'(dbg_state), 16'(ST_SHIFT));
        bus.start = 1'b1;
        @(posedge i_clk);
        #1 bus.start = 1'b0;
        wait_dones(d0 + 1, FRAME_LEN + 20);
        idle(50);
        check("shift_start_ignored", 16'(done_cnt - d0), 16'd1);

        // Reset at the third o_clk rising edge aborts the frame.
        randomize_ram();
        exp_q.push_back({K_RD, 12'd0});
        for (int b = B - 1; b >= B - 3; b--) exp_q.push_back({K_DAI, 11'd0, ram[0][b]});
        d0 = done_cnt;
        pulse_start();
        rises = 0;
        n = 0;
        prev = 1'b0;
        while (rises < 3 && n < 100) begin
            @(posedge i_clk);
            #1;
            if (bus.sclk && !prev) rises++;
            prev = bus.sclk;
            n++;
        end
        check("abort_third_edge", 16'(rises), 16'd3);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check_zero_outputs("abort");
        i_rst = 1'b0;
        idle(50);
        check("abort_no_done", 16'(done_cnt - d0), 16'd0);
        check("abort_queue_drained", 16'(exp_q.size()), 16'd0);

        // A fresh frame after the abort starts again from address 0.
        randomize_ram();
        push_frame();
        d0 = done_cnt;
        pulse_start();
        wait_dones(d0 + 1, FRAME_LEN + 20);
        idle(10);
        check("final_queue_drained", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
